cernbe_master: RTL and testbench
================================

Name: cernbe_master

Overview:
- Initiator for the CERN-BE 16-bit memory bus: drives VMEAddr/VMERdMem/VMEWrMem/VMEWrData and waits for VMERdDone/VMEWrDone from a CERN-BE register-map responder.
- Host side is a simple single-outstanding request port carrying 16- or 32-bit accesses. A 32-bit access is split into two 16-bit bus cycles, high half at the even 16-bit address and low half at the odd one.
- Sits between the local CPU/host fabric and generated register maps; bounded by a per-cycle timeout.

Parameters:
AW, 8, bus byte-address width; VMEAddr spans [AW-1:1]
TIMEOUT, 255, max wait cycles per bus cycle before error; 0 disables timeout

Ports:
Clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_i  in  1  host request, sampled only when busy_o=0
we_i  in  1  1=write, 0=read
size_i  in  1  0=16-bit, 1=32-bit
adr_i  in  AW-1  16-bit-word address [AW-1:1]; adr_i[1] ignored when size_i=1
wdat_i  in  32  write data; [15:0] used for 16-bit
busy_o  out  1  transaction in progress
ack_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle timeout pulse, coincident with ack_o
rdat_o  out  32  read data, valid with ack_o, held until next ack
VMEAddr  out  AW-1  bus word address [AW-1:1]
VMERdMem  out  1  read strobe
VMEWrMem  out  1  write strobe
VMEWrData  out  16  bus write data
VMERdData  in  16  bus read data, valid with VMERdDone
VMERdDone  in  1  read completion
VMEWrDone  in  1  write completion

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE immediately; all outputs 0, rdat_o=0, timeout counter 0. A reset during any state aborts the transaction with no ack.
- Registered outputs only. FSM states: IDLE, STB, WAIT, DONE.
- IDLE: req_i=1 -> latch we/size/adr/wdat, set phase (HI if size_i=1, else SINGLE). Go to STB; busy_o=1 from the next cycle.
- STB: exactly one cycle with VMERdMem or VMEWrMem =1. VMEAddr = {adr[AW-1:2],0} for the HI phase, {adr[AW-1:2],1} for the LO phase, adr_i for SINGLE. VMEWrData = wdat[31:16] for HI, wdat[15:0] for LO/SINGLE. Load the timeout counter, then go to WAIT.
- WAIT: strobes are 0; VMEAddr and VMEWrData are held stable. Only the Done matching the direction is accepted; the opposite Done is ignored. Done is not sampled during STB.
  - Done and phase=HI: a read captures rdat[31:16]; phase becomes LO; next state STB.
  - Done and phase LO/SINGLE: a read captures rdat[15:0], and rdat[31:16] is cleared for SINGLE; next state DONE.
  - No Done: the counter increments. On TIMEOUT consecutive WAIT cycles without Done, go to DONE with error set. A pending LO half is abandoned and rdat_o is forced to 0.
- DONE: ack_o=1 for one cycle (err_o=1 if error); busy_o=0 next cycle; return to IDLE.
- Latency, 16-bit: req at cycle 0, strobe at 1, earliest Done at 2, ack at 3. For 32-bit, the LO strobe is issued the cycle after HI Done; minimum total is 5 cycles req->ack.
- Requests while busy_o=1 are ignored and not queued. req_i held high in the DONE cycle is not accepted; the next request is taken in IDLE.
- Done at exactly the TIMEOUT-th wait cycle counts as success (Done has priority over timeout).
- A VMEAddr wrap at the top of the space is not special: the LO address is always the HI address | 1.

Decomposition:
- Package cernbe_pkg: state enum (IDLE, STB, WAIT, DONE), phase enum (SINGLE, HI, LO), size encoding constants, TIMEOUT counter width function.
- Sub-module cernbe_timeout: loadable counter with enable and expiry flag; TIMEOUT=0 ties expiry low.
- FSM and datapath stay in cernbe_master.

Test Plan:
- 16-bit write adr=0x02, wdat=0x1234, responder WrDone 1 cycle after strobe -> one VMEWrMem pulse, VMEAddr=1, VMEWrData=0x1234; ack_o 3 cycles after req, err_o=0.
- 32-bit read adr=0x04, responder returns 0xCAFE then 0xBEEF -> strobes at VMEAddr=2 then 3; rdat_o=0xCAFEBEEF with ack_o.
- 32-bit write with 4-cycle Done delay on HI -> address/data stable throughout WAIT; LO strobe the cycle after HI Done with VMEWrData=wdat[15:0].
- TIMEOUT=8, responder silent -> ack_o=err_o=1 after 8 WAIT cycles; a 32-bit read issues no LO strobe and rdat_o=0. Also: Done on wait cycle 8 -> success.
- VMEWrDone pulsed during a read, and req_i pulsed while busy -> both ignored; only one transaction completes.
- rst_n asserted mid-WAIT of a 32-bit read -> outputs 0 asynchronously, no ack; a new 16-bit read after release completes normally.

Source files
------------

// File: rtl/cernbe_pkg.sv
// Shared types and helpers for the CERN-BE bus initiator.
//   state_t       : initiator FSM states
//   phase_t       : which half of an access the current bus cycle carries
//   SIZE_16/32    : host size_i encoding
//   tmo_cnt_width : bits needed for a wait counter that must reach TIMEOUT-1
package cernbe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STB  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PH_SINGLE = 2'd0,
    PH_HI     = 2'd1,
    PH_LO     = 2'd2
  } phase_t;

  localparam logic SIZE_16 = 1'b0;
  localparam logic SIZE_32 = 1'b1;

  function automatic int tmo_cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/cernbe_timeout.sv
// Per-bus-cycle wait counter.
//   clk, rst_n : clock, async active-low reset
//   load       : clear the count (issued while the strobe is on the bus)
//   en         : count one more wait cycle without Done
//   expired    : the current wait cycle is the TIMEOUT-th one; never set when TIMEOUT=0
module cernbe_timeout
  import cernbe_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = tmo_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  // Saturates at LAST so a disabled timeout never wraps back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (load)                cnt <= '0;
    else if (en && (cnt != LAST)) cnt <= cnt + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/cernbe_master.sv
// Host-to-CERN-BE bus initiator. One outstanding host request; 32-bit
// accesses become two 16-bit bus cycles (high half at the even word,
// low half at the odd word). Every output is registered.
//   Clk, rst_n                     : clock, async active-low reset
//   req_i/we_i/size_i/adr_i/wdat_i : host request, taken only in IDLE
//   busy_o/ack_o/err_o/rdat_o      : host status and read data
//   VMEAddr/VMERdMem/VMEWrMem/VMEWrData : bus request side
//   VMERdData/VMERdDone/VMEWrDone       : bus responder side
module cernbe_master
  import cernbe_pkg::*;
#(
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          Clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic          we_i,
  input  logic          size_i,
  input  logic [AW-1:1] adr_i,
  input  logic [31:0]   wdat_i,
  output logic          busy_o,
  output logic          ack_o,
  output logic          err_o,
  output logic [31:0]   rdat_o,
  output logic [AW-1:1] VMEAddr,
  output logic          VMERdMem,
  output logic          VMEWrMem,
  output logic [15:0]   VMEWrData,
  input  logic [15:0]   VMERdData,
  input  logic          VMERdDone,
  input  logic          VMEWrDone
);

  state_t        state;
  phase_t        phase;
  logic          we_q;
  logic [AW-1:1] adr_q;
  logic [15:0]   wlo_q;
  logic [15:0]   rhi_q;
  logic          done_hit;
  logic          expired;

  // Only the Done matching the access direction counts, and only in WAIT.
  assign done_hit = (state == ST_WAIT) && (we_q ? VMEWrDone : VMERdDone);

  cernbe_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (Clk),
    .rst_n   (rst_n),
    .load    (state == ST_STB),
    .en      ((state == ST_WAIT) && !done_hit),
    .expired (expired)
  );

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase     <= PH_SINGLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wlo_q     <= '0;
      rhi_q     <= '0;
      busy_o    <= 1'b0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      rdat_o    <= '0;
      VMEAddr   <= '0;
      VMERdMem  <= 1'b0;
      VMEWrMem  <= 1'b0;
      VMEWrData <= '0;
    end else begin
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      VMERdMem <= 1'b0;
      VMEWrMem <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            we_q     <= we_i;
            adr_q    <= adr_i;
            wlo_q    <= wdat_i[15:0];
            phase    <= (size_i == SIZE_32) ? PH_HI : PH_SINGLE;
            busy_o   <= 1'b1;
            VMERdMem <= !we_i;
            VMEWrMem <= we_i;
            // adr_i[1] is ignored for 32-bit accesses: the high half is the even word.
            VMEAddr   <= (size_i == SIZE_32) ? {adr_i[AW-1:2], 1'b0} : adr_i;
            VMEWrData <= (size_i == SIZE_16) ? wdat_i[15:0] : wdat_i[31:16];
            state     <= ST_STB;
          end
        end
        ST_STB: state <= ST_WAIT;
        ST_WAIT: begin
          if (done_hit) begin
            if (phase == PH_HI) begin
              if (!we_q) rhi_q <= VMERdData;
              phase     <= PH_LO;
              VMERdMem  <= !we_q;
              VMEWrMem  <= we_q;
              VMEAddr   <= {adr_q[AW-1:2], 1'b1};
              VMEWrData <= wlo_q;
              state     <= ST_STB;
            end else begin
              if (!we_q)
                rdat_o <= (phase == PH_LO) ? {rhi_q, VMERdData} : {16'h0000, VMERdData};
              ack_o <= 1'b1;
              state <= ST_DONE;
            end
          end else if (expired) begin
            // Any pending low half is dropped; the host sees zero data.
            rdat_o <= '0;
            ack_o  <= 1'b1;
            err_o  <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cernbe_master.sv
module tb_cernbe_master;

  localparam int AW = 8;
  localparam int TO = 8;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        req_i, we_i, size_i;
  logic [7:1]  adr_i;
  logic [31:0] wdat_i;
  logic        busy_o, ack_o, err_o;
  logic [31:0] rdat_o;
  logic [7:1]  VMEAddr;
  logic        VMERdMem, VMEWrMem;
  logic [15:0] VMEWrData;
  logic [15:0] VMERdData;
  logic        VMERdDone, VMEWrDone;

  cernbe_master #(.AW(AW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .adr_i(adr_i), .wdat_i(wdat_i), .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o),
    .rdat_o(rdat_o), .VMEAddr(VMEAddr), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMEWrData(VMEWrData), .VMERdData(VMERdData), .VMERdDone(VMERdDone),
    .VMEWrDone(VMEWrDone)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Expected outputs for the current cycle, set by the stimulus tasks.
  bit          chk_en = 0;
  bit          exp_busy, exp_rd, exp_wr, exp_ack, exp_err, exp_addr_v;
  logic [6:0]  exp_addr;
  logic [15:0] exp_wd;
  logic [31:0] exp_rdat;
  logic [31:0] m_rdat = 32'h0;

  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", busy_o, exp_busy);
      check("rdmem", VMERdMem, exp_rd);
      check("wrmem", VMEWrMem, exp_wr);
      check("ack", ack_o, exp_ack);
      check("err", err_o, exp_err);
      check("rdat", rdat_o, exp_rdat);
      if (exp_addr_v) begin
        check("addr", VMEAddr, exp_addr);
        check("wdata", VMEWrData, exp_wd);
      end
    end
  end

  // Bus-side monitor for the directed literal checks.
  logic [23:0] slog[$];
  int ack_cyc = -1;
  bit ack_err = 0;
  int ack_cnt = 0;
  always @(negedge Clk) begin
    if (rst_n && (VMERdMem || VMEWrMem)) slog.push_back({VMEWrMem, VMEAddr, VMEWrData});
    if (ack_o) begin
      ack_cyc = cyc;
      ack_err = err_o;
      ack_cnt++;
    end
  end

  function automatic logic [23:0] sget(input int i);
    return (i < slog.size()) ? slog[i] : 24'h0;
  endfunction

  task automatic set_idle_exp();
    exp_busy = 0; exp_rd = 0; exp_wr = 0; exp_ack = 0; exp_err = 0;
    exp_addr_v = 0; exp_addr = '0; exp_wd = '0; exp_rdat = m_rdat;
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_ack"}, ack_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_rdat"}, rdat_o, 0);
    check({tag, "_addr"}, VMEAddr, 0);
    check({tag, "_rdmem"}, VMERdMem, 0);
    check({tag, "_wrmem"}, VMEWrMem, 0);
    check({tag, "_wdata"}, VMEWrData, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      req_i = 0; we_i = 1'($urandom); size_i = 1'($urandom);
      adr_i = 7'($urandom); wdat_i = $urandom;
      VMERdDone = 0; VMEWrDone = 0; VMERdData = 16'($urandom);
      set_idle_exp();
    end
  endtask

  // One host transaction. d1/d2: Done arrives in that WAIT cycle of the
  // high/single and low bus cycle; a value above TO means the responder is silent.
  // abort >= 0 pulls reset that many cycles after the request.
  task automatic run_txn(input bit we, input bit sz, input logic [6:0] adr,
                         input logic [31:0] wd, input int d1, input int d2,
                         input logic [15:0] r1, input logic [15:0] r2,
                         input bit noise, input int abort, output int c0);
    int s1, s2, dc1, dc2, e1, e2, ack;
    bit to, in1, in2, match, stbn, opp;
    logic [6:0]  a1, a2;
    logic [15:0] w1, w2;
    logic [31:0] new_rdat;
    @(posedge Clk); #1;
    c0 = cyc;
    s1 = c0 + 1; s2 = -1; dc1 = -1; dc2 = -1; e2 = -1; to = 0;
    a1 = sz ? {adr[6:1], 1'b0} : adr;
    w1 = sz ? wd[31:16] : wd[15:0];
    a2 = {adr[6:1], 1'b1};
    w2 = wd[15:0];
    if (d1 <= TO) begin
      dc1 = s1 + d1; e1 = dc1;
      if (sz) begin
        s2 = dc1 + 1;
        if (d2 <= TO) begin dc2 = s2 + d2; e2 = dc2; ack = dc2 + 1; end
        else begin e2 = s2 + TO; ack = e2 + 1; to = 1; end
      end else ack = dc1 + 1;
    end else begin
      e1 = s1 + TO; ack = e1 + 1; to = 1;
    end
    if (to) new_rdat = 32'h0;
    else if (we) new_rdat = m_rdat;
    else new_rdat = sz ? {r1, r2} : {16'h0000, r1};

    for (int c = c0; c <= ack; c++) begin
      if (c != c0) begin @(posedge Clk); #1; end
      if (c == c0) begin
        req_i = 1; we_i = we; size_i = sz; adr_i = adr; wdat_i = wd;
      end else begin
        req_i = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (c == ack) req_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        we_i = 1'($urandom); size_i = 1'($urandom);
        adr_i = 7'($urandom); wdat_i = $urandom;
      end
      match = (c == dc1) || (c == dc2);
      stbn  = noise && ((c == s1) || (c == s2)) && ($urandom_range(0, 1) == 1);
      opp   = noise && ($urandom_range(0, 2) == 0);
      VMERdDone = we ? opp : (match || stbn);
      VMEWrDone = we ? (match || stbn) : opp;
      VMERdData = (c == dc1) ? r1 : (c == dc2) ? r2 : 16'($urandom);

      in1 = (c >= s1) && (c <= e1);
      in2 = (s2 >= 0) && (c >= s2) && (c <= e2);
      exp_busy   = (c != c0);
      exp_rd     = !we && ((c == s1) || (c == s2));
      exp_wr     = we && ((c == s1) || (c == s2));
      exp_addr_v = in1 || in2;
      exp_addr   = in2 ? a2 : a1;
      exp_wd     = in2 ? w2 : w1;
      exp_ack    = (c == ack);
      exp_err    = to && (c == ack);
      exp_rdat   = (c == ack) ? new_rdat : m_rdat;

      if (abort >= 0 && c == c0 + abort) begin
        chk_en = 0;
        #2 rst_n = 0;
        #1 chk_all_zero("async_rst");
        req_i = 0; VMERdDone = 0; VMEWrDone = 0;
        @(negedge Clk);
        check("rst_no_ack", ack_o, 0);
        @(posedge Clk); #2 rst_n = 1;
        m_rdat = 32'h0;
        set_idle_exp();
        chk_en = 1;
        return;
      end
    end
    m_rdat = new_rdat;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n0;
    int d1, d2, p;
    rst_n = 0; req_i = 0; we_i = 0; size_i = 0; adr_i = '0; wdat_i = '0;
    VMERdData = '0; VMERdDone = 0; VMEWrDone = 0;
    repeat (3) @(posedge Clk);
    #1 chk_all_zero("reset");
    @(posedge Clk); #2 rst_n = 1;
    set_idle_exp();
    chk_en = 1;
    idle(2);

    // 16-bit write, Done one cycle after the strobe.
    slog.delete();
    run_txn(1, 0, 7'h01, 32'h0000_1234, 1, 1, 16'h0, 16'h0, 0, -1, c0);
    idle(1);
    check("t1_nstb", slog.size(), 1);
    check("t1_stb", sget(0), {1'b1, 7'h01, 16'h1234});
    check("t1_lat", 32'(ack_cyc - c0), 3);
    check("t1_err", ack_err, 0);

    // 32-bit read at byte 0x04.
    slog.delete();
    run_txn(0, 1, 7'h02, 32'h0, 1, 1, 16'hCAFE, 16'hBEEF, 0, -1, c0);
    idle(1);
    check("t2_nstb", slog.size(), 2);
    check("t2_adr_hi", sget(0) >> 16, {1'b0, 7'h02});
    check("t2_adr_lo", sget(1) >> 16, {1'b0, 7'h03});
    check("t2_rdat", rdat_o, 32'hCAFE_BEEF);
    check("t2_lat", 32'(ack_cyc - c0), 5);

    // 32-bit write, slow high half.
    slog.delete();
    run_txn(1, 1, 7'h08, 32'hA5A5_5A5A, 4, 1, 16'h0, 16'h0, 0, -1, c0);
    idle(1);
    check("t3_nstb", slog.size(), 2);
    check("t3_stb_hi", sget(0), {1'b1, 7'h08, 16'hA5A5});
    check("t3_stb_lo", sget(1), {1'b1, 7'h09, 16'h5A5A});
    check("t3_lat", 32'(ack_cyc - c0), 8);

    // Silent responder on a 32-bit read.
    slog.delete();
    run_txn(0, 1, 7'h10, 32'h0, TO + 1, 1, 16'h0, 16'h0, 0, -1, c0);
    idle(1);
    check("t4_nstb", slog.size(), 1);
    check("t4_err", ack_err, 1);
    check("t4_rdat", rdat_o, 32'h0);
    check("t4_lat", 32'(ack_cyc - c0), 10);

    // Done on the last allowed wait cycle.
    run_txn(0, 0, 7'h11, 32'h0, TO, 1, 16'h7777, 16'h0, 0, -1, c0);
    idle(1);
    check("t5_err", ack_err, 0);
    check("t5_rdat", rdat_o, 32'h0000_7777);
    check("t5_lat", 32'(ack_cyc - c0), 10);

    // Wrong-direction Done and requests while busy.
    slog.delete();
    n0 = ack_cnt;
    run_txn(0, 1, 7'h31, 32'h0, 2, 3, 16'h1111, 16'h2222, 1, -1, c0);
    idle(2);
    check("t6_nstb", slog.size(), 2);
    check("t6_nack", 32'(ack_cnt - n0), 1);
    check("t6_rdat", rdat_o, 32'h1111_2222);
    check("t6_lat", 32'(ack_cyc - c0), 8);

    // Reset in the middle of a 32-bit read, then a normal 16-bit read.
    n0 = ack_cnt;
    run_txn(0, 1, 7'h20, 32'h0, TO + 1, 1, 16'h0, 16'h0, 0, 4, c0);
    check("t7_noack", 32'(ack_cnt - n0), 0);
    idle(1);
    run_txn(0, 0, 7'h21, 32'h0, 2, 1, 16'h5A5A, 16'h0, 0, -1, c0);
    idle(1);
    check("t7_rdat", rdat_o, 32'h0000_5A5A);
    check("t7_lat", 32'(ack_cyc - c0), 4);

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 200; i++) begin
      p = $urandom_range(0, 9);
      d1 = (p == 0) ? TO + 1 : (p == 1) ? TO : $urandom_range(1, 4);
      p = $urandom_range(0, 9);
      d2 = (p == 0) ? TO + 1 : (p == 1) ? TO : $urandom_range(1, 4);
      run_txn(1'($urandom), 1'($urandom), 7'($urandom), $urandom, d1, d2,
              16'($urandom), 16'($urandom), 1, -1, c0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
